// File: rtl/niosfirmware_cpu_dct_packer_if.sv
// Code-in / frame-out handshake bundle for the DCT trace packer.
// slave is the packer side; master is the producer/consumer side.
interface niosfirmware_cpu_dct_packer_if;
  logic        code_valid;
  logic [1:0]  code;
  logic        code_ready;
  logic        frame_valid;
  logic [29:0] frame_data;
  logic [3:0]  frame_count;
  logic        frame_ready;

  modport slave (
    input  code_valid, code, frame_ready,
    output code_ready, frame_valid, frame_data, frame_count
  );

  modport master (
    output code_valid, code, frame_ready,
    input  code_ready, frame_valid, frame_data, frame_count
  );
endinterface

// File: rtl/niosfirmware_cpu_dct_packer.sv
// Packs 2-bit trace codes into 15-code / 30-bit frames with a one-deep output register.
// Optional idle-flush timer enabled by defining DCT_IDLE_FLUSH_EN.
module niosfirmware_cpu_dct_packer #(
  parameter int IDLE_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           test_ending,
  niosfirmware_cpu_dct_packer_if.slave   bus,
  output logic [29:0]                    dct_buffer,
  output logic [3:0]                     dct_count,
  output logic                           test_has_ended
);

  typedef struct packed {
    logic [29:0] data;
    logic [3:0]  count;
  } frame_t;

  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_idle
    $error("IDLE_CYCLES must be in 1..255");
  end

  frame_t      frame_q;
  logic        frame_vld;
  logic        flush_pend;
  logic        out_free, accept, flush_req, seal, pend_set;
  logic [29:0] code_slot;

  assign bus.frame_valid = frame_vld;
  assign bus.frame_data  = frame_q.data;
  assign bus.frame_count = frame_q.count;

  assign out_free       = !frame_vld || bus.frame_ready;
  assign bus.code_ready = (dct_count != 4'd15 || out_free) && !test_has_ended;
  assign accept         = bus.code_valid && bus.code_ready;
  // test_ending behaves as a flush that never goes away
  assign flush_req      = flush || flush_pend || test_ending;
  assign seal           = out_free && (dct_count == 4'd15 || (flush_req && dct_count != 4'd0));
  assign code_slot      = {28'd0, bus.code} << {dct_count, 1'b0};

`ifdef DCT_IDLE_FLUSH_EN
  logic [7:0] idle_cnt;
  logic       idle_inc, idle_hit;

  assign idle_inc = dct_count != 4'd0 && !accept && !seal
                    && idle_cnt != 8'(IDLE_CYCLES);
  assign idle_hit = idle_inc && (idle_cnt + 8'd1) == 8'(IDLE_CYCLES);
  assign pend_set = flush || idle_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                idle_cnt <= 8'd0;
    else if (accept || seal)  idle_cnt <= 8'd0;
    else if (idle_inc)        idle_cnt <= idle_cnt + 8'd1;
  end
`else
  assign pend_set = flush;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (seal) begin
      // the code accepted on a sealing edge opens the next accumulator
      dct_buffer <= accept ? {28'd0, bus.code} : 30'd0;
      dct_count  <= accept ? 4'd1 : 4'd0;
    end else if (accept) begin
      dct_buffer <= dct_buffer | code_slot;
      dct_count  <= dct_count + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_q   <= '0;
      frame_vld <= 1'b0;
    end else if (seal) begin
      frame_q   <= '{data: dct_buffer, count: dct_count};
      frame_vld <= 1'b1;
    end else if (frame_vld && bus.frame_ready) begin
      frame_vld <= 1'b0;
    end
  end

  // a flush against an empty accumulator with nothing arriving is dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          flush_pend <= 1'b0;
    else if (seal)      flush_pend <= 1'b0;
    else if (pend_set)  flush_pend <= dct_count != 4'd0 || accept;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      test_has_ended <= 1'b0;
    else if (test_ending && dct_count == 4'd0 && !frame_vld)
      test_has_ended <= 1'b1;
  end

endmodule
